// File: rtl/bloom_hash_gen.sv
// rtl/bloom_hash_gen.sv - splits a byte stream into words and issues bloom filter insert/lookup hash pairs
// Optional counters: define BLOOM_HASH_WORD_COUNT_EN to add word_count/check_count outputs.
`timescale 1ns/1ps
module bloom_hash_gen #(
    parameter logic [7:0]  DELIM        = 8'h20,
    parameter logic [7:0]  HASH2_SEED   = 8'h00,
    parameter int unsigned MAX_WORD_LEN = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        char_last,
    input  logic        mode,
    output logic [7:0]  hash1,
    output logic [7:0]  hash2,
    output logic        bf_write,
    output logic        bf_check,
    input  logic        bf_ready,
    output logic        trunc
`ifdef BLOOM_HASH_WORD_COUNT_EN
    ,
    output logic [15:0] word_count,
    output logic [15:0] check_count
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    localparam logic [7:0] MAX_LEN = 8'(MAX_WORD_LEN);

    state_t     state, state_next;
    logic [7:0] h1, h2, len;
    logic       word_mode, trunc_q;
    logic       accept, is_delim, emit_done;

    function automatic logic [7:0] h1_step(input logic [7:0] h, input logic [7:0] c);
        return {h[6:0], h[7]} ^ c;
    endfunction

    // h*31 + c, modulo 256
    function automatic logic [7:0] h2_step(input logic [7:0] h, input logic [7:0] c);
        return (h << 5) - h + c;
    endfunction

    assign is_delim  = (char_data == DELIM);
    assign accept    = char_valid & char_ready;
    assign emit_done = (state == EMIT) & bf_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        char_ready = 1'b0;
        bf_write   = 1'b0;
        bf_check   = 1'b0;
        case (state)
            IDLE: begin
                char_ready = reset;
                if (accept && !is_delim) begin
                    state_next = char_last ? EMIT : ACCUM;
                end
            end
            ACCUM: begin
                char_ready = reset;
                if (accept && (is_delim || char_last)) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                bf_write = ~word_mode;
                bf_check = word_mode;
                if (bf_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h1        <= 8'h00;
            h2        <= 8'h00;
            len       <= 8'h00;
            trunc_q   <= 1'b0;
            word_mode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !is_delim) begin
                        h1        <= char_data;
                        h2        <= h2_step(HASH2_SEED, char_data);
                        len       <= 8'd1;
                        word_mode <= mode;
                    end
                end
                ACCUM: begin
                    // Bytes past the length cap are swallowed but flag the word
                    if (accept && !is_delim) begin
                        if (len < MAX_LEN) begin
                            h1  <= h1_step(h1, char_data);
                            h2  <= h2_step(h2, char_data);
                            len <= len + 8'd1;
                        end else begin
                            trunc_q <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bf_ready) begin
                        h1      <= 8'h00;
                        h2      <= 8'h00;
                        len     <= 8'h00;
                        trunc_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hash1 = h1;
    assign hash2 = h2;
    assign trunc = trunc_q;

`ifdef BLOOM_HASH_WORD_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_count  <= 16'h0000;
            check_count <= 16'h0000;
        end else if (emit_done) begin
            word_count <= word_count + 16'd1;
            if (word_mode) begin
                check_count <= check_count + 16'd1;
            end
        end
    end
`else
    logic unused_emit_done;
    assign unused_emit_done = emit_done;
`endif

endmodule

// File: tb/tb_bloom_hash_gen.sv
// tb/tb_bloom_hash_gen.sv - scoreboard bench for bloom_hash_gen (default and MAX_WORD_LEN=2 instances)
`timescale 1ns/1ps
module tb_bloom_hash_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       char_valid = 1'b0, char_last = 1'b0, mode = 1'b0, bf_ready = 1'b0;
    logic [7:0] char_data = 8'h00;

    logic       char_ready0, bf_write0, bf_check0, trunc0;
    logic [7:0] hash1_0, hash2_0;
    logic       char_ready1, bf_write1, bf_check1, trunc1;
    logic [7:0] hash1_1, hash2_1;
`ifdef BLOOM_HASH_WORD_COUNT_EN
    logic [15:0] word_count0, check_count0, word_count1, check_count1;
`endif

    bloom_hash_gen dut0 (
        .clock(clock), .reset(reset), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready0), .char_last(char_last), .mode(mode),
        .hash1(hash1_0), .hash2(hash2_0), .bf_write(bf_write0), .bf_check(bf_check0),
        .bf_ready(bf_ready), .trunc(trunc0)
`ifdef BLOOM_HASH_WORD_COUNT_EN
        , .word_count(word_count0), .check_count(check_count0)
`endif
    );

    bloom_hash_gen #(.MAX_WORD_LEN(2)) dut1 (
        .clock(clock), .reset(reset), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready1), .char_last(char_last), .mode(mode),
        .hash1(hash1_1), .hash2(hash2_1), .bf_write(bf_write1), .bf_check(bf_check1),
        .bf_ready(bf_ready), .trunc(trunc1)
`ifdef BLOOM_HASH_WORD_COUNT_EN
        , .word_count(word_count1), .check_count(check_count1)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] h1;
        logic [7:0] h2;
        logic       tr;
        logic       md;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   req_count = 0;
    int   req_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic exp_t model(input string s, input int maxl, input logic md);
        exp_t e;
        int a = 0, b = 0, len = 0;
        e.tr = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            int c = int'(s[i]) & 255;
            if (len < maxl) begin
                a = ((((a << 1) | (a >> 7)) & 255) ^ c);
                b = (b * 31 + c) % 256;
                len++;
            end else begin
                e.tr = 1'b1;
            end
        end
        e.h1 = a[7:0];
        e.h2 = b[7:0];
        e.md = md;
        return e;
    endfunction

    // Scoreboard: a request with bf_ready high is accepted on the next rising edge
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset && (bf_write0 || bf_check0) && bf_ready) begin
            req_count++;
            req_cyc.push_back(cyc);
            checks++;
            if (q0.size() == 0 || q1.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req h1=%h h2=%h required none", hash1_0, hash2_0);
            end else begin
                e = q0.pop_front();
                if ({hash1_0, hash2_0, trunc0, bf_check0, bf_write0} !== {e.h1, e.h2, e.tr, e.md, ~e.md}) begin
                    errors++;
                    $display("FAIL req_dut0 got h1=%h h2=%h tr=%b chk=%b wr=%b required h1=%h h2=%h tr=%b md=%b",
                             hash1_0, hash2_0, trunc0, bf_check0, bf_write0, e.h1, e.h2, e.tr, e.md);
                end
                e = q1.pop_front();
                checks++;
                if ({hash1_1, hash2_1, trunc1, bf_check1, bf_write1} !== {e.h1, e.h2, e.tr, e.md, ~e.md}) begin
                    errors++;
                    $display("FAIL req_dut1 got h1=%h h2=%h tr=%b chk=%b wr=%b required h1=%h h2=%h tr=%b md=%b",
                             hash1_1, hash2_1, trunc1, bf_check1, bf_write1, e.h1, e.h2, e.tr, e.md);
                end
            end
        end
    end

    task automatic expect_word(input string s, input logic md);
        q0.push_back(model(s, 16, md));
        q1.push_back(model(s, 2, md));
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        int n = 0;
        @(negedge clock);
        char_valid = 1'b1;
        char_data  = c;
        char_last  = last;
        while (!char_ready0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%h char_ready=%b required 1", c, char_ready0);
        end
        @(posedge clock);
        #1;
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_at_end);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], last_at_end && (i == s.len() - 1));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bf_write0 || bf_check0) && n < 30) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL idle_timeout bf_write=%b bf_check=%b required 0", bf_write0, bf_check0);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({char_ready0, bf_write0, bf_check0, hash1_0, hash2_0, trunc0} !== 20'h0) begin
            errors++;
            $display("FAIL reset_dut0 got rdy=%b wr=%b chk=%b h1=%h h2=%h tr=%b required all 0",
                     char_ready0, bf_write0, bf_check0, hash1_0, hash2_0, trunc0);
        end
        checks++;
        if ({char_ready1, bf_write1, bf_check1, hash1_1, hash2_1, trunc1} !== 20'h0) begin
            errors++;
            $display("FAIL reset_dut1 got rdy=%b wr=%b chk=%b h1=%h h2=%h tr=%b required all 0",
                     char_ready1, bf_write1, bf_check1, hash1_1, hash2_1, trunc1);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (char_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b required 1", char_ready0);
        end
    endtask

    task automatic test_write_latency();
        mode = 1'b0;
        bf_ready = 1'b1;
        expect_word("test", 1'b0);
        send_str("test", 1'b0);
        checks++;
        if (bf_write0 !== 1'b0) begin
            errors++;
            $display("FAIL early_write got %b required 0", bf_write0);
        end
        send(8'h20, 1'b0);
        checks++;
        if ({bf_write0, bf_check0, hash1_0, hash2_0, trunc0, trunc1} !== {2'b10, 8'hA4, 8'h92, 2'b01}) begin
            errors++;
            $display("FAIL write_latency got wr=%b chk=%b h1=%h h2=%h tr0=%b tr1=%b required wr=1 chk=0 h1=a4 h2=92 tr0=0 tr1=1",
                     bf_write0, bf_check0, hash1_0, hash2_0, trunc0, trunc1);
        end
        wait_idle();
    endtask

    task automatic test_check_last();
        bf_ready = 1'b0;
        mode = 1'b1;
        expect_word("sad", 1'b1);
        send_str("sad", 1'b1);
        mode = 1'b0;
        checks++;
        if ({bf_check0, bf_write0, char_ready0, hash1_0, hash2_0} !== {3'b100, 8'h6B, 8'hD6}) begin
            errors++;
            $display("FAIL check_last got chk=%b wr=%b rdy=%b h1=%h h2=%h required chk=1 wr=0 rdy=0 h1=6b h2=d6",
                     bf_check0, bf_write0, char_ready0, hash1_0, hash2_0);
        end
        @(negedge clock);
        checks++;
        if ({bf_check0, char_ready0} !== 2'b10) begin
            errors++;
            $display("FAIL check_hold got chk=%b rdy=%b required chk=1 rdy=0", bf_check0, char_ready0);
        end
        @(posedge clock);
        #1;
        bf_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_delims();
        int base;
        bf_ready = 1'b1;
        base = req_count;
        expect_word("test", 1'b0);
        send(8'h20, 1'b0);
        send(8'h20, 1'b0);
        send_str("test", 1'b0);
        send(8'h20, 1'b0);
        send(8'h20, 1'b0);
        send(8'h20, 1'b1);
        repeat (5) @(negedge clock);
        checks++;
        if (req_count - base !== 1) begin
            errors++;
            $display("FAIL delim_count got %0d required 1", req_count - base);
        end
    endtask

    task automatic test_backpressure();
        bf_ready = 1'b0;
        expect_word("test", 1'b0);
        send_str("test ", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if ({hash1_0, hash2_0, bf_write0, char_ready0} !== {8'hA4, 8'h92, 2'b10}) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d got h1=%h h2=%h wr=%b rdy=%b required h1=a4 h2=92 wr=1 rdy=0",
                         i, hash1_0, hash2_0, bf_write0, char_ready0);
            end
        end
        @(posedge clock);
        #1;
        bf_ready = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({char_ready0, bf_write0, hash1_0, hash2_0} !== {2'b10, 16'h0000}) begin
            errors++;
            $display("FAIL backpressure_release got rdy=%b wr=%b h1=%h h2=%h required rdy=1 wr=0 h1=00 h2=00",
                     char_ready0, bf_write0, hash1_0, hash2_0);
        end
    endtask

    task automatic test_trunc_boundary();
        bf_ready = 1'b1;
        expect_word("ok", 1'b0);
        expect_word("hello", 1'b1);
        send_str("ok ", 1'b0);
        mode = 1'b1;
        send_str("hello ", 1'b0);
        mode = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int c0;
        bf_ready = 1'b1;
        c0 = req_cyc.size();
        expect_word("a", 1'b0);
        expect_word("b", 1'b0);
        expect_word("c", 1'b0);
        send_str("a b c ", 1'b0);
        wait_idle();
        repeat (2) @(negedge clock);
        checks++;
        if (req_cyc.size() - c0 !== 3) begin
            errors++;
            $display("FAIL b2b_count got %0d required 3", req_cyc.size() - c0);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (req_cyc[c0 + i] - req_cyc[c0 + i - 1] !== 3) begin
                    errors++;
                    $display("FAIL b2b_spacing got %0d required 3", req_cyc[c0 + i] - req_cyc[c0 + i - 1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        bf_ready = 1'b0;
        mode = 1'b0;
        send_str("test ", 1'b0);
        checks++;
        if (bf_write0 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_emit got %b required 1", bf_write0);
        end
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bf_write0, bf_check0, hash1_0, hash2_0, bf_write1, hash1_1, hash2_1, char_ready0} !== 36'h0) begin
            errors++;
            $display("FAIL reset_mid_emit got wr=%b chk=%b h1=%h h2=%h wr1=%b h1_1=%h h2_1=%h rdy=%b required all 0",
                     bf_write0, bf_check0, hash1_0, hash2_0, bf_write1, hash1_1, hash2_1, char_ready0);
        end
        @(negedge clock);
        reset = 1'b1;
        bf_ready = 1'b1;
        expect_word("sad", 1'b0);
        send_str("sad ", 1'b0);
        wait_idle();
`ifdef BLOOM_HASH_WORD_COUNT_EN
        @(negedge clock);
        checks++;
        if ({word_count0, check_count0} !== {16'd1, 16'd0}) begin
            errors++;
            $display("FAIL counters_after_reset got wc=%0d cc=%0d required wc=1 cc=0", word_count0, check_count0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_check_last();
        test_delims();
        test_backpressure();
        test_trunc_boundary();
        test_back_to_back();
        test_reset_mid_emit();
        repeat (3) @(negedge clock);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got q0=%0d q1=%0d required 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout sim time exceeded");
        $fatal(1, "watchdog");
    end

endmodule
